// File: rtl/gol_rle_loader.sv
// Life RLE pattern loader: decodes an ASCII RLE byte stream into one-cell-per-cycle grid writes.
// Define GOL_LOADER_CLEAR_EN to zero the whole grid before each load.
module gol_rle_loader #(
  parameter  int GRID_SIZE = 16,
  parameter  int COUNT_W   = 8,
  localparam int ADDR_W    = $clog2(GRID_SIZE*GRID_SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int XY_W = $clog2(GRID_SIZE+1);
  localparam int CW   = COUNT_W + 4;
  localparam int SW   = ((XY_W > COUNT_W) ? XY_W : COUNT_W) + 1;
  localparam logic [XY_W-1:0]    GRID_LIM  = XY_W'(GRID_SIZE);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
`ifdef GOL_LOADER_CLEAR_EN
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(GRID_SIZE*GRID_SIZE-1);
`endif

  typedef enum logic [2:0] {
    IDLE,
`ifdef GOL_LOADER_CLEAR_EN
    CLEAR,
`endif
    ACCEPT,
    EMIT,
    DONE,
    ERROR
  } state_t;

  state_t             state_q, state_d;
  logic [XY_W-1:0]    x_q, x_d, y_q, y_d;
  logic [COUNT_W-1:0] count_q, count_d, run_q, run_d;
  logic               cell_q, cell_d;
`ifdef GOL_LOADER_CLEAR_EN
  logic [ADDR_W-1:0]  clr_q, clr_d;
`endif

  logic               in_bounds, is_digit;
  logic [ADDR_W-1:0]  cell_addr;
  logic [COUNT_W-1:0] run_len;

  // Decimal accumulate with saturation at the register maximum.
  function automatic logic [COUNT_W-1:0] count_push(input logic [COUNT_W-1:0] c,
                                                    input logic [3:0] digit);
    logic [CW-1:0] t;
    t = CW'(c) * CW'(10) + CW'(digit);
    return (t > CW'(COUNT_MAX)) ? COUNT_MAX : t[COUNT_W-1:0];
  endfunction

  // Row advance saturates at GRID_SIZE so later cells fall out of bounds.
  function automatic logic [XY_W-1:0] row_advance(input logic [XY_W-1:0] row,
                                                  input logic [COUNT_W-1:0] step);
    logic [SW-1:0] t;
    t = SW'(row) + SW'(step);
    return (t >= SW'(GRID_SIZE)) ? GRID_LIM : t[XY_W-1:0];
  endfunction

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    count_d   = count_q;
    run_d     = run_q;
    cell_d    = cell_q;
`ifdef GOL_LOADER_CLEAR_EN
    clr_d     = clr_q;
`endif
    in_ready  = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    in_bounds = (x_q < GRID_LIM) && (y_q < GRID_LIM);
    cell_addr = ADDR_W'(x_q) + ADDR_W'(y_q) * ADDR_W'(GRID_SIZE);
    run_len   = (count_q == '0) ? COUNT_W'(1) : count_q;
    is_digit  = (in_data >= 8'h30) && (in_data <= 8'h39);

    case (state_q)
      IDLE, DONE, ERROR: begin
        done  = (state_q == DONE);
        error = (state_q == ERROR);
        if (start) begin
          x_d     = '0;
          y_d     = '0;
          count_d = '0;
`ifdef GOL_LOADER_CLEAR_EN
          clr_d   = '0;
          state_d = CLEAR;
`else
          state_d = ACCEPT;
`endif
        end
      end
`ifdef GOL_LOADER_CLEAR_EN
      CLEAR: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = clr_q;
        clr_d   = clr_q + 1'b1;
        if (clr_q == LAST_ADDR) state_d = ACCEPT;
      end
`endif
      ACCEPT: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid) begin
          if (is_digit) begin
            count_d = count_push(count_q, in_data[3:0]);
          end else begin
            case (in_data)
              "b", "o": begin
                run_d   = run_len;
                cell_d  = (in_data == "o");
                count_d = '0;
                state_d = EMIT;
              end
              "$": begin
                y_d     = row_advance(y_q, run_len);
                x_d     = '0;
                count_d = '0;
              end
              "!":                        state_d = DONE;
              " ", 8'h09, 8'h0d, 8'h0a:   count_d = count_q;
              default:                    state_d = ERROR;
            endcase
          end
        end
      end
      EMIT: begin
        busy = 1'b1;
        if (in_bounds) begin
          wr_en   = 1'b1;
          wr_addr = cell_addr;
          wr_data = cell_q;
        end
        run_d = run_q - 1'b1;
        if (x_q < GRID_LIM) x_d = x_q + 1'b1;
        if (run_q <= COUNT_W'(1)) state_d = ACCEPT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      count_q <= '0;
      run_q   <= '0;
      cell_q  <= 1'b0;
`ifdef GOL_LOADER_CLEAR_EN
      clr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      count_q <= count_d;
      run_q   <= run_d;
      cell_q  <= cell_d;
`ifdef GOL_LOADER_CLEAR_EN
      clr_q   <= clr_d;
`endif
    end
  end

endmodule

// File: tb/tb_gol_rle_loader.sv
// Directed bench for gol_rle_loader: a 4x4 and a 16x16 instance driven by RLE byte streams.
module tb_gol_rle_loader;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       start4 = 1'b0, in_valid4 = 1'b0;
  logic [7:0] in_data4 = 8'h00;
  logic       in_ready4, wr_en4, wr_data4, busy4, done4, error4;
  logic [3:0] wr_addr4;

  logic       start16 = 1'b0, in_valid16 = 1'b0;
  logic [7:0] in_data16 = 8'h00;
  logic       in_ready16, wr_en16, wr_data16, busy16, done16, error16;
  logic [7:0] wr_addr16;

  int nassert = 0;
  int nfail   = 0;
  int w4[$];
  int w16[$];

  always #5 clk = ~clk;

  gol_rle_loader #(.GRID_SIZE(4)) u4 (
    .clk(clk), .reset(reset), .start(start4), .in_data(in_data4), .in_valid(in_valid4),
    .in_ready(in_ready4), .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4),
    .busy(busy4), .done(done4), .error(error4)
  );

  gol_rle_loader #(.GRID_SIZE(16)) u16 (
    .clk(clk), .reset(reset), .start(start16), .in_data(in_data16), .in_valid(in_valid16),
    .in_ready(in_ready16), .wr_en(wr_en16), .wr_addr(wr_addr16), .wr_data(wr_data16),
    .busy(busy16), .done(done16), .error(error16)
  );

  // Write log, one entry per strobe, encoded as addr*2 + data.
  always @(negedge clk) begin
    if (!reset && wr_en4)  w4.push_back(int'(wr_addr4) * 2 + int'(wr_data4));
    if (!reset && wr_en16) w16.push_back(int'(wr_addr16) * 2 + int'(wr_data16));
  end

  function automatic logic rdy(int g);
    return (g == 4) ? in_ready4 : in_ready16;
  endfunction

  function automatic logic fin(int g);
    return (g == 4) ? (done4 | error4) : (done16 | error16);
  endfunction

  function automatic int qsize(int g);
    return (g == 4) ? w4.size() : w16.size();
  endfunction

  function automatic int qat(int g, int i);
    return (g == 4) ? w4[i] : w16[i];
  endfunction

  task automatic qclear(int g);
    if (g == 4) w4.delete();
    else        w16.delete();
  endtask

  task automatic chk(string tag, int obs, int exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic outs_zero(int g, string tag);
    if (g == 4) begin
      chk1({tag, " in_ready"}, in_ready4, 1'b0);
      chk1({tag, " wr_en"},    wr_en4,    1'b0);
      chk1({tag, " wr_data"},  wr_data4,  1'b0);
      chk1({tag, " busy"},     busy4,     1'b0);
      chk1({tag, " done"},     done4,     1'b0);
      chk1({tag, " error"},    error4,    1'b0);
      chk({tag, " wr_addr"},   int'(wr_addr4), 0);
    end else begin
      chk1({tag, " in_ready"}, in_ready16, 1'b0);
      chk1({tag, " wr_en"},    wr_en16,    1'b0);
      chk1({tag, " wr_data"},  wr_data16,  1'b0);
      chk1({tag, " busy"},     busy16,     1'b0);
      chk1({tag, " done"},     done16,     1'b0);
      chk1({tag, " error"},    error16,    1'b0);
      chk({tag, " wr_addr"},   int'(wr_addr16), 0);
    end
  endtask

  task automatic pulse_start(int g);
    @(negedge clk);
    if (g == 4) start4 = 1'b1; else start16 = 1'b1;
    @(posedge clk);
    #1;
    start4  = 1'b0;
    start16 = 1'b0;
  endtask

  // Start a load and check the latency to the first in_ready (and the clear sweep if built in).
  task automatic do_start(int g);
    int n;
    bit ok;
    qclear(g);
    pulse_start(g);
    @(negedge clk);
    n = 0;
    while (!rdy(g) && n < 400) begin
      @(negedge clk);
      n++;
    end
`ifdef GOL_LOADER_CLEAR_EN
    chk("load latency", n + 1, g * g + 1);
    chk("clear write count", qsize(g), g * g);
    ok = 1'b1;
    for (int i = 0; i < qsize(g) && i < g * g; i++) if (qat(g, i) != i * 2) ok = 1'b0;
    chk("clear write order", int'(ok), 1);
`else
    ok = 1'b1;
    chk("load latency", n + 1, 1);
    chk("no clear writes", qsize(g), 0);
`endif
    qclear(g);
  endtask

  task automatic send(int g, byte c);
    int n;
    @(negedge clk);
    n = 0;
    while (!rdy(g) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("in_ready wait bound", n, 0);
    if (g == 4) begin in_data4 = c; in_valid4 = 1'b1; end
    else        begin in_data16 = c; in_valid16 = 1'b1; end
    @(posedge clk);
    #1;
    in_valid4  = 1'b0;
    in_valid16 = 1'b0;
  endtask

  task automatic feed(int g, string s);
    for (int i = 0; i < s.len(); i++) send(g, s[i]);
  endtask

  // Cycles with in_ready low following the last transfer.
  task automatic gap(int g, output int n);
    @(negedge clk);
    n = 0;
    while (!rdy(g) && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_end(int g);
    int n;
    n = 0;
    while (!fin(g) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("done/error wait bound", n, 0);
  endtask

  task automatic check_writes(int g, string tag, int exp[$]);
    chk({tag, " write count"}, qsize(g), exp.size());
    for (int i = 0; i < exp.size() && i < qsize(g); i++) chk({tag, " write"}, qat(g, i), exp[i]);
    qclear(g);
  endtask

  initial begin
    int e[$];
    int n;

    // Reset state
    repeat (2) @(negedge clk);
    outs_zero(4, "reset4");
    outs_zero(16, "reset16");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk1("idle busy4", busy4, 1'b0);
    chk1("idle in_ready16", in_ready16, 1'b0);

    // "2o$obo!" on 4x4
    do_start(4);
    feed(4, "2o$obo!");
    wait_end(4);
    chk1("t1 done", done4, 1'b1);
    chk1("t1 busy", busy4, 1'b0);
    chk1("t1 in_ready", in_ready4, 1'b0);
    chk1("t1 error", error4, 1'b0);
    e = '{1, 3, 9, 10, 13};
    check_writes(4, "t1", e);

    // "3b12o!" on 16x16 with in_ready gaps
    do_start(16);
    feed(16, "3b");
    gap(16, n);
    chk("t2 gap 3b", n, 3);
    feed(16, "12o");
    gap(16, n);
    chk("t2 gap 12o", n, 12);
    feed(16, "!");
    wait_end(16);
    chk1("t2 done", done16, 1'b1);
    e.delete();
    for (int a = 0; a < 3; a++)  e.push_back(a * 2);
    for (int a = 3; a < 15; a++) e.push_back(a * 2 + 1);
    check_writes(16, "t2", e);

    // "20o!" on 16x16: x saturates, last 4 cells dropped
    do_start(16);
    feed(16, "20o");
    gap(16, n);
    chk("t3 gap 20o", n, 20);
    feed(16, "!");
    wait_end(16);
    e.delete();
    for (int a = 0; a < 16; a++) e.push_back(a * 2 + 1);
    check_writes(16, "t3", e);

    // "2$o!" on 4x4
    do_start(4);
    feed(4, "2$o!");
    wait_end(4);
    e = '{17};
    check_writes(4, "t4", e);

    // Count saturation at 255 and row saturation at GRID_SIZE
    do_start(4);
    feed(4, "999b");
    gap(4, n);
    chk("t5 saturated run", n, 255);
    feed(4, "9$o!");
    wait_end(4);
    chk1("t5 done", done4, 1'b1);
    e = '{0, 2, 4, 6};
    check_writes(4, "t5", e);

    // Illegal byte, then recovery
    do_start(4);
    feed(4, "oz");
    repeat (3) @(negedge clk);
    chk1("t6 error", error4, 1'b1);
    chk1("t6 in_ready", in_ready4, 1'b0);
    chk1("t6 busy", busy4, 1'b0);
    chk1("t6 done", done4, 1'b0);
    chk1("t6 wr_en", wr_en4, 1'b0);
    e = '{1};
    check_writes(4, "t6", e);
    do_start(4);
    chk1("t6 error cleared", error4, 1'b0);
    chk1("t6 busy again", busy4, 1'b1);
    feed(4, " bo\n!");
    wait_end(4);
    chk1("t6 reload done", done4, 1'b1);
    e = '{0, 3};
    check_writes(4, "t6 reload", e);

    // start while busy is ignored
    do_start(16);
    feed(16, "3o");
    pulse_start(16);
    feed(16, "2b");
    gap(16, n);
    pulse_start(16);
    feed(16, "!");
    wait_end(16);
    chk1("t7 done", done16, 1'b1);
    e = '{1, 3, 5, 6, 8};
    check_writes(16, "t7", e);

    // Reset mid-EMIT
    do_start(16);
    feed(16, "9o");
    repeat (3) @(negedge clk);
    chk1("t8 mid-run wr_en", wr_en16, 1'b1);
    reset = 1'b1;
    #1;
    outs_zero(16, "t8 reset");
    @(negedge clk);
    outs_zero(16, "t8 reset cycle");
    chk1("t8 done4 cleared", done4, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk1("t8 idle busy", busy16, 1'b0);
    chk1("t8 idle in_ready", in_ready16, 1'b0);
    do_start(16);
    feed(16, "o!");
    wait_end(16);
    e = '{1};
    check_writes(16, "t8 reload", e);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
